// File: rtl/pipe_io_ports_if.sv
// Data-memory side bus of the pipe_io_ports responder.
// The CPU decoder is the master; the I/O block is the slave.
interface pipe_io_ports_if;
  logic        io_sel;
  logic        io_we;
  logic [4:0]  io_addr;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;

  modport master (
    output io_sel, io_we, io_addr, io_wdata,
    input  io_rdata
  );

  modport slave (
    input  io_sel, io_we, io_addr, io_wdata,
    output io_rdata
  );
endinterface

// File: rtl/pipe_io_ports.sv
// Memory-mapped switch/key/hex/led I/O for pipeline_computer_01.
// Define PIPE_IO_IRQ_EN to add IRQ_MASK (0x18) and a key-event irq.
module pipe_io_ports #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             resetn,
  pipe_io_ports_if.slave   bus,
  input  logic [9:0]       sw,
  input  logic [3:1]       key,
  output logic [6:0]       hex5,
  output logic [6:0]       hex4,
  output logic [6:0]       hex3,
  output logic [6:0]       hex2,
  output logic [6:0]       hex1,
  output logic [6:0]       hex0,
  output logic [9:0]       led,
  output logic             irq
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] R_SW    = 3'd0;
  localparam logic [2:0] R_KEY   = 3'd1;
  localparam logic [2:0] R_EDGE  = 3'd2;
  localparam logic [2:0] R_HEX   = 3'd3;
  localparam logic [2:0] R_LED   = 3'd4;
  localparam logic [2:0] R_BLANK = 3'd5;
  localparam logic [2:0] R_MASK  = 3'd6;

  logic [9:0]       sw_s1, sw_s2;
  logic [2:0]       key_s1, key_s2;
  logic [2:0]       pressed;
  logic [2:0]       deb;
  logic [CNT_W-1:0] cnt [3];
  logic [2:0]       flip;
  logic [2:0]       rise;
  logic [2:0]       key_edge;
  logic [2:0]       edge_clr;
  logic [23:0]      hex_data;
  logic [5:0]       blank;
  logic [9:0]       led_q;
  logic [6:0]       hex_q [6];
  logic [2:0]       idx;
  logic             wr, rd;
  logic [31:0]      rd_val;
  logic             unused;

  assign idx    = bus.io_addr[4:2];
  assign wr     = bus.io_sel & bus.io_we;
  assign rd     = bus.io_sel & ~bus.io_we;
  assign unused = ^{bus.io_addr[1:0], bus.io_wdata[31:24]};

  function automatic logic [6:0] seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Keys are active-low on the board; invert after sync so 1 = pressed
  assign pressed = ~key_s2;

  always_comb begin
    flip = '0;
    for (int i = 0; i < 3; i++)
      flip[i] = (pressed[i] != deb[i]) && (cnt[i] == LAST);
  end

  assign rise     = flip & pressed;
  assign edge_clr = (wr && idx == R_EDGE) ? bus.io_wdata[2:0] : 3'b0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      key_s1 <= '1;
      key_s2 <= '1;
      deb    <= '0;
      for (int i = 0; i < 3; i++)
        cnt[i] <= '0;
      key_edge <= '0;
    end else begin
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
      key_s1 <= key;
      key_s2 <= key_s1;
      deb    <= deb ^ flip;
      for (int i = 0; i < 3; i++) begin
        if (pressed[i] == deb[i] || flip[i])
          cnt[i] <= '0;
        else
          cnt[i] <= cnt[i] + 1'b1;
      end
      // a fresh edge beats a simultaneous software clear
      key_edge <= (key_edge & ~edge_clr) | rise;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hex_data <= '0;
      blank    <= '0;
      led_q    <= '0;
    end else if (wr) begin
      case (idx)
        R_HEX:   hex_data <= bus.io_wdata[23:0];
        R_LED:   led_q    <= bus.io_wdata[9:0];
        R_BLANK: blank    <= bus.io_wdata[5:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < 6; k++)
        hex_q[k] <= 7'h40;
    end else begin
      for (int k = 0; k < 6; k++)
        hex_q[k] <= blank[k] ? 7'h7F : seg(hex_data[4*k +: 4]);
    end
  end

  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];
  assign hex5 = hex_q[5];
  assign led  = led_q;

`ifdef PIPE_IO_IRQ_EN
  logic [2:0] irq_mask;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      irq_mask <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr && idx == R_MASK)
        irq_mask <= bus.io_wdata[2:0];
      irq <= |(key_edge & irq_mask);
    end
  end
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rd_val = '0;
    case (idx)
      R_SW:    rd_val = {22'b0, sw_s2};
      R_KEY:   rd_val = {29'b0, deb};
      R_EDGE:  rd_val = {29'b0, key_edge};
      R_HEX:   rd_val = {8'b0, hex_data};
      R_LED:   rd_val = {22'b0, led_q};
      R_BLANK: rd_val = {26'b0, blank};
`ifdef PIPE_IO_IRQ_EN
      R_MASK:  rd_val = {29'b0, irq_mask};
`endif
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      bus.io_rdata <= '0;
    else if (rd)
      bus.io_rdata <= rd_val;
  end

endmodule

// File: tb/tb_pipe_io_ports.sv
// Self-checking bench for pipe_io_ports (DEBOUNCE_CYCLES = 4).
// Read results go through a scoreboard queue filled when a read is issued.
module tb_pipe_io_ports;

  logic       clk;
  logic       resetn;
  logic [9:0] sw;
  logic [3:1] key;
  logic [6:0] hex5, hex4, hex3, hex2, hex1, hex0;
  logic [9:0] led;
  logic       irq;

  pipe_io_ports_if bus ();

  pipe_io_ports #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus.slave),
    .sw(sw),
    .key(key),
    .hex5(hex5),
    .hex4(hex4),
    .hex3(hex3),
    .hex2(hex2),
    .hex1(hex1),
    .hex0(hex0),
    .led(led),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } rw_vec_t;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } sb_t;

  rw_vec_t    rw_tab [6];
  sb_t        sb [$];
  logic [6:0] seg_tab [16];
  int         checks = 0;
  int         errors = 0;

`ifdef PIPE_IO_IRQ_EN
  localparam logic [31:0] MASK_RB = 32'h7;
`else
  localparam logic [31:0] MASK_RB = 32'h0;
`endif

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.io_sel   = 1'b1;
    bus.io_we    = 1'b1;
    bus.io_addr  = a;
    bus.io_wdata = d;
    tick(1);
    bus.io_sel   = 1'b0;
    bus.io_we    = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] e,
                    input string name);
    sb_t s;
    s.exp  = e;
    s.name = name;
    sb.push_back(s);
    bus.io_sel  = 1'b1;
    bus.io_we   = 1'b0;
    bus.io_addr = a;
    tick(1);
    bus.io_sel  = 1'b0;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      s = sb.pop_front();
      chk(s.name, {32'b0, bus.io_rdata}, {32'b0, s.exp});
    end
  endtask

  task automatic chk_hex(input string name, input logic [41:0] e);
    chk(name, {22'b0, hex5, hex4, hex3, hex2, hex1, hex0}, {22'b0, e});
  endtask

  initial begin
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    rw_tab[0] = '{5'h0C, 32'hFFFF_FFFF, 32'h00FF_FFFF};
    rw_tab[1] = '{5'h10, 32'h1234_5555, 32'h0000_0155};
    rw_tab[2] = '{5'h14, 32'hFFFF_FFFF, 32'h0000_003F};
    rw_tab[3] = '{5'h1C, 32'hFFFF_FFFF, 32'h0000_0000};
    rw_tab[4] = '{5'h18, 32'h0000_0007, MASK_RB};
    rw_tab[5] = '{5'h03, 32'hFFFF_FFFF, 32'h0000_02AA};

    resetn       = 1'b0;
    sw           = 10'b1010101010;
    key          = 3'b111;
    bus.io_sel   = 1'b0;
    bus.io_we    = 1'b0;
    bus.io_addr  = '0;
    bus.io_wdata = '0;
    tick(3);
    chk("reset_rdata", {32'b0, bus.io_rdata}, 64'h0);
    chk("reset_led", {54'b0, led}, 64'h0);
    chk_hex("reset_hex", {6{7'h40}});
    chk("reset_irq", {63'b0, irq}, 64'h0);

    resetn = 1'b1;
    tick(2);
    rd(5'h00, 32'h2AA, "sw_read");
    rd(5'h04, 32'h0, "key_idle");
    rd(5'h08, 32'h0, "edge_idle");

    key = 3'b011;
    tick(10);
    rd(5'h04, 32'h4, "key3_level");
    rd(5'h08, 32'h4, "key3_edge");

    key = 3'b010;
    tick(2);
    key = 3'b011;
    tick(8);
    rd(5'h04, 32'h4, "glitch_level");
    rd(5'h08, 32'h4, "glitch_edge");

    // key2 debounce completes on the 6th edge after the key changes
    key = 3'b001;
    tick(5);
    wr(5'h08, 32'h4);
    rd(5'h08, 32'h2, "w1c_race");
    rd(5'h04, 32'h6, "two_keys");
    wr(5'h08, 32'h7);
    rd(5'h08, 32'h0, "w1c_all");
    key = 3'b111;
    tick(10);
    rd(5'h04, 32'h0, "release_level");
    rd(5'h08, 32'h0, "release_no_edge");

    wr(5'h0C, 32'h00C0_FFEE);
    tick(1);
    chk_hex("hex_c0ffee", {7'h46, 7'h40, 7'h0E, 7'h0E, 7'h06, 7'h06});
    wr(5'h14, 32'h21);
    tick(1);
    chk_hex("hex_blank", {7'h7F, 7'h40, 7'h0E, 7'h0E, 7'h06, 7'h7F});
    rd(5'h0C, 32'h00C0_FFEE, "hex_readback");

    wr(5'h10, 32'hFFFF_FFFF);
    chk("led_write", {54'b0, led}, 64'h3FF);
    rd(5'h10, 32'h3FF, "led_read");
    tick(2);
    chk("rdata_hold", {32'b0, bus.io_rdata}, 64'h3FF);
    rd(5'h1C, 32'h0, "reserved_read");

    for (int i = 0; i < 6; i++) begin
      wr(rw_tab[i].addr, rw_tab[i].wdata);
      rd(rw_tab[i].addr, rw_tab[i].exp, $sformatf("rw_tab%0d", i));
    end

    wr(5'h14, 32'h0);
    for (int d = 0; d < 16; d++) begin
      logic [3:0] n;
      n = 4'(d);
      wr(5'h0C, {8'h0, {6{n}}});
      tick(1);
      chk_hex($sformatf("seg_%0h", d), {6{seg_tab[d]}});
    end

    bus.io_sel   = 1'b0;
    bus.io_we    = 1'b1;
    bus.io_addr  = 5'h10;
    bus.io_wdata = 32'h0;
    tick(2);
    bus.io_we    = 1'b0;
    chk("nosel_led", {54'b0, led}, 64'h155);

`ifdef PIPE_IO_IRQ_EN
    wr(5'h18, 32'h1);
    key = 3'b110;
    tick(10);
    chk("irq_set", {63'b0, irq}, 64'h1);
    wr(5'h08, 32'h1);
    tick(1);
    chk("irq_clear", {63'b0, irq}, 64'h0);
    key = 3'b111;
    tick(10);
    key = 3'b101;
    tick(10);
    chk("irq_masked", {63'b0, irq}, 64'h0);
    rd(5'h08, 32'h2, "irq_masked_edge");
    key = 3'b111;
    tick(10);
    wr(5'h08, 32'h7);
`else
    key = 3'b110;
    tick(10);
    chk("irq_tied", {63'b0, irq}, 64'h0);
    rd(5'h08, 32'h1, "edge_key1");
    key = 3'b111;
    tick(10);
    wr(5'h08, 32'h7);
`endif

    key = 3'b110;
    tick(10);
    key = 3'b111;
    resetn = 1'b0;
    #1;
    chk("mid_reset_led", {54'b0, led}, 64'h0);
    chk("mid_reset_rdata", {32'b0, bus.io_rdata}, 64'h0);
    chk("mid_reset_irq", {63'b0, irq}, 64'h0);
    tick(2);
    chk_hex("mid_reset_hex", {6{7'h40}});
    resetn = 1'b1;
    tick(3);
    rd(5'h08, 32'h0, "mid_reset_edge");
    rd(5'h04, 32'h0, "mid_reset_key");
    rd(5'h10, 32'h0, "mid_reset_ledreg");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
